// File: rtl/tt_sram_responder.sv
// Synthesizable stand-in for the 1rw SRAM macro: flop-array storage cleared after
// reset, byte-masked writes, 1-cycle registered reads, sticky error flags and counters.
module tt_sram_responder #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ram_csb0,
  input  logic             ram_web0,
  input  logic [3:0]       ram_wmask0,
  input  logic [8:0]       ram_addr0,
  input  logic [31:0]      ram_din0,
  output logic [31:0]      ram_dout0,
  output logic             busy,
  output logic             err_oob,
  output logic             err_busy,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [9:0]       DEPTH_L  = 10'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t           state_reg;
  logic [PTR_W-1:0] ptr_reg;
  logic [31:0]      mem [0:DEPTH-1];

  logic             access;
  logic             in_range;
  logic             rd_en;
  logic             wr_en;
  logic [PTR_W-1:0] idx;
  logic [31:0]      wr_word;

  assign access   = ~ram_csb0;
  assign in_range = {1'b0, ram_addr0} < DEPTH_L;
  assign idx      = ram_addr0[PTR_W-1:0];
  assign rd_en    = (state_reg == ST_READY) && access && ram_web0;
  assign wr_en    = (state_reg == ST_READY) && access && !ram_web0;

  // Merge enabled byte lanes of the write data over the current word contents.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign wr_word[8*gi +: 8] = ram_wmask0[gi] ? ram_din0[8*gi +: 8] : mem[idx][8*gi +: 8];
    end
  endgenerate

  // Storage carries no reset; its contents are defined only by the clear sweep.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CLEAR) begin
      mem[ptr_reg] <= '0;
    end else if (wr_en && in_range) begin
      mem[idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_CLEAR;
      ptr_reg   <= '0;
      busy      <= 1'b1;
      ram_dout0 <= '0;
      err_oob   <= 1'b0;
      err_busy  <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      case (state_reg)
        ST_CLEAR: begin
          if (access) err_busy <= 1'b1;
          if (ptr_reg == PTR_LAST) begin
            state_reg <= ST_READY;
            busy      <= 1'b0;
          end else begin
            ptr_reg <= ptr_reg + 1'b1;
          end
        end
        default: begin
          if (access && !in_range) err_oob <= 1'b1;
          if (rd_en) begin
            ram_dout0 <= in_range ? mem[idx] : '0;
            if (rd_count != CNT_MAX) rd_count <= rd_count + 1'b1;
          end
          if (wr_en && wr_count != CNT_MAX) wr_count <= wr_count + 1'b1;
        end
      endcase
    end
  end

endmodule
